input4_and_sweep_ctrl: RTL and testbench

//  Sequencer that exhaustively exercises one input4_and_b gate instance in hardware.
//  On start it drives all 16 {a,b,c,d} vectors in ascending order, waits DWELL cycles
//  for each, and compares e/f/g against the golden function.

---
 rtl/input4_and_pkg.sv | 28 ++
 rtl/input4_and_ref.sv | 17 +
 rtl/input4_and_sweep_ctrl.sv | 171 +++++++++++++++++
 tb/tb_input4_and_sweep_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/input4_and_pkg.sv
// Shared definitions for the input4_and_b built-in self-test sequencer.
//   state_e : sweep FSM states
//   NUM_VEC : number of {a,b,c,d} vectors in one sweep
//   VEC_W   : vector index width
//   golden  : reference function of input4_and_b, returns {e,f,g}
package input4_and_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam int NUM_VEC = 16;
    localparam int VEC_W   = 4;

    // vec[3]=a (MSB) .. vec[0]=d; result is {e, f, g}.
    function automatic logic [2:0] golden(input logic [VEC_W-1:0] vec);
        logic e_v;
        logic f_v;
        e_v = vec[3] & vec[2];
        f_v = vec[1] & vec[0];
        return {e_v, f_v, e_v & f_v};
    endfunction

endpackage

// File: rtl/input4_and_ref.sv
// Combinational golden model of input4_and_b.
//   vec   in  4  stimulus vector {a,b,c,d}
//   exp_e out 1  expected e = a&b
//   exp_f out 1  expected f = c&d
//   exp_g out 1  expected g = a&b&c&d
module input4_and_ref
    import input4_and_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic             exp_e,
    output logic             exp_f,
    output logic             exp_g
);

    assign {exp_e, exp_f, exp_g} = golden(vec);

endmodule

// File: rtl/input4_and_sweep_ctrl.sv
// Built-in self-test sequencer for one input4_and_b gate.
// On start it walks {a,b,c,d} through 0..15, lets each vector settle for
// DWELL cycles, then compares the gate outputs against the golden model.
//   clk, rst_n           clock (rising edge), async active-low reset
//   start                one-cycle sweep request, taken only in IDLE
//   abort                cancel; returns to IDLE from any state
//   e_in, f_in, g_in     gate outputs under test
//   a, b, c, d           registered gate stimulus ({a,b,c,d} = vector index)
//   busy                 high in APPLY/SETTLE/CHECK
//   done                 one-cycle pulse on sweep completion
//   pass                 sticky result of the last completed sweep
//   err_cnt              failing vectors in current/last sweep
//   first_fail/first_vld first failing vector index and its valid flag
module input4_and_sweep_ctrl
    import input4_and_pkg::*;
#(
    parameter int unsigned DWELL = 2,
    parameter int unsigned DW_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             e_in,
    input  logic             f_in,
    input  logic             g_in,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [4:0]       err_cnt,
    output logic [VEC_W-1:0] first_fail,
    output logic             first_vld
);

    // Last SETTLE count value; only reachable when DWELL > 0.
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'((DWELL == 0) ? 0 : DWELL - 1);
    localparam logic [VEC_W-1:0] LAST_IDX  = VEC_W'(NUM_VEC - 1);

    state_e           state_q,  state_d;
    logic [VEC_W-1:0] idx_q,    idx_d;
    logic [DW_W-1:0]  cnt_q,    cnt_d;
    logic [VEC_W-1:0] vec_q,    vec_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             pass_q,   pass_d;
    logic [4:0]       err_q,    err_d;
    logic [VEC_W-1:0] ff_q,     ff_d;
    logic             fv_q,     fv_d;

    logic exp_e, exp_f, exp_g;
    logic mismatch;

    input4_and_ref u_ref (
        .vec   (idx_q),
        .exp_e (exp_e),
        .exp_f (exp_f),
        .exp_g (exp_g)
    );

    assign mismatch = ({e_in, f_in, g_in} != {exp_e, exp_f, exp_g});

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        pass_d  = pass_q;
        err_d   = err_q;
        ff_d    = ff_q;
        fv_d    = fv_q;

        if (abort) begin
            // Abort keeps err_cnt/first_* so the partial result stays visible.
            state_d = IDLE;
            vec_d   = '0;
            pass_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = APPLY;
                        idx_d   = '0;
                        err_d   = '0;
                        fv_d    = 1'b0;
                        pass_d  = 1'b0;
                    end
                end
                APPLY: begin
                    vec_d = idx_q;
                    cnt_d = '0;
                    state_d = (DWELL > 0) ? SETTLE : CHECK;
                end
                SETTLE: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = CHECK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_d = err_q + 5'd1;
                        if (!fv_q) begin
                            ff_d = idx_q;
                            fv_d = 1'b1;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        // Result is published together with the done pulse.
                        pass_d  = (err_d == 5'd0);
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = APPLY;
                    end
                end
                DONE: begin
                    vec_d   = '0;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    vec_d   = '0;
                end
            endcase
        end

        // Status flags are registered copies of the next state.
        done_d = (state_d == DONE);
        busy_d = (state_d == APPLY) || (state_d == SETTLE) || (state_d == CHECK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ff_q    <= '0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            fv_q    <= fv_d;
        end
    end

    assign {a, b, c, d} = vec_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign err_cnt      = err_q;
    assign first_fail   = ff_q;
    assign first_vld    = fv_q;

endmodule

// File: tb/tb_input4_and_sweep_ctrl.sv
// Bench for input4_and_sweep_ctrl: a DWELL=2 instance and a DWELL=0 instance,
// each driving a behavioural input4_and_b with a selectable stuck-at fault.
module tb_input4_and_sweep_ctrl;

    // fault codes: 0 none, 1 g sa0, 2 f sa1, 3 e sa1, 4 e sa0, 5 g sa1, 6 f sa0
    typedef struct {
        int fault;
        int exp_err;
        int exp_ff;
        int exp_fv;
        int exp_pass;
    } vec_t;

    logic clk = 1'b0;
    logic rst1_n, rst2_n;
    logic start1, abort1, start2, abort2;
    int   fault;

    logic a1, b1, c1, d1, busy1, done1, pass1, fv1;
    logic [4:0] err1;
    logic [3:0] ff1;
    logic e1, f1, g1;

    logic a2, b2, c2, d2, busy2, done2, pass2, fv2;
    logic [4:0] err2;
    logic [3:0] ff2;
    logic e2, f2, g2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    input4_and_sweep_ctrl #(.DWELL(2), .DW_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .start(start1), .abort(abort1),
        .e_in(e1), .f_in(f1), .g_in(g1),
        .a(a1), .b(b1), .c(c1), .d(d1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .first_fail(ff1), .first_vld(fv1)
    );

    input4_and_sweep_ctrl #(.DWELL(0), .DW_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .start(start2), .abort(abort2),
        .e_in(e2), .f_in(f2), .g_in(g2),
        .a(a2), .b(b2), .c(c2), .d(d2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .first_fail(ff2), .first_vld(fv2)
    );

    // Behavioural gate with fault injection.
    function automatic logic [2:0] gate(input logic a, b, c, d, input int flt);
        logic e, f, g;
        e = a & b;
        f = c & d;
        g = a & b & c & d;
        case (flt)
            1: g = 1'b0;
            2: f = 1'b1;
            3: e = 1'b1;
            4: e = 1'b0;
            5: g = 1'b1;
            6: f = 1'b0;
            default: ;
        endcase
        return {e, f, g};
    endfunction

    always_comb {e1, f1, g1} = gate(a1, b1, c1, d1, fault);
    always_comb {e2, f2, g2} = gate(a2, b2, c2, d2, fault);

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start1();
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    // Called in sweep cycle cyc; returns the cycle where done was seen.
    task automatic wait_done1(input int from_cyc, input bit walk, output int cyc);
        cyc = from_cyc;
        while (!done1 && cyc < 200) begin
            if (walk && (cyc % 4 == 0))
                chk("walk_abcd", int'({a1, b1, c1, d1}), cyc / 4 - 1);
            @(negedge clk);
            cyc++;
        end
    endtask

    vec_t tbl[7];
    int   cyc;
    int   seen;

    initial begin
        tbl[0] = '{0,  0,  0, 0, 1};
        tbl[1] = '{1,  1, 15, 1, 0};
        tbl[2] = '{2, 12,  0, 1, 0};
        tbl[3] = '{3, 12,  0, 1, 0};
        tbl[4] = '{4,  4, 12, 1, 0};
        tbl[5] = '{5, 15,  0, 1, 0};
        tbl[6] = '{6,  4,  3, 1, 0};

        fault = 0;
        rst1_n = 1'b0; rst2_n = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; start2 = 1'b0; abort2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_abcd",  int'({a1, b1, c1, d1}), 0);
        chk("rst_busy",  int'(busy1), 0);
        chk("rst_done",  int'(done1), 0);
        chk("rst_pass",  int'(pass1), 0);
        chk("rst_err",   int'(err1), 0);
        chk("rst_ff",    int'(ff1), 0);
        chk("rst_fv",    int'(fv1), 0);
        rst1_n = 1'b1; rst2_n = 1'b1;
        @(negedge clk);

        // Full sweeps against each gate variant.
        for (int i = 0; i < 7; i++) begin
            fault = tbl[i].fault;
            pulse_start1();
            chk("busy_start", int'(busy1), 1);
            wait_done1(1, i == 0, cyc);
            chk("done_cycle", cyc, 65);
            chk("err_cnt",    int'(err1), tbl[i].exp_err);
            chk("first_vld",  int'(fv1), tbl[i].exp_fv);
            if (tbl[i].exp_fv != 0)
                chk("first_fail", int'(ff1), tbl[i].exp_ff);
            chk("pass",       int'(pass1), tbl[i].exp_pass);
            @(negedge clk);
            chk("done_pulse", int'(done1), 0);
            chk("abcd_idle",  int'({a1, b1, c1, d1}), 0);
            chk("pass_sticky", int'(pass1), tbl[i].exp_pass);
        end

        // Abort while vector 7 is settling (cycle 30), f stuck-at-1.
        fault = 2;
        pulse_start1();
        repeat (29) @(negedge clk);
        chk("abort_pre_abcd", int'({a1, b1, c1, d1}), 7);
        chk("abort_pre_busy", int'(busy1), 1);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        chk("abort_busy", int'(busy1), 0);
        chk("abort_abcd", int'({a1, b1, c1, d1}), 0);
        chk("abort_pass", int'(pass1), 0);
        chk("abort_err",  int'(err1), 6);
        chk("abort_ff",   int'(ff1), 0);
        chk("abort_fv",   int'(fv1), 1);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (done1 || busy1) seen++;
        end
        chk("abort_no_done", seen, 0);

        // Clean sweep after abort, with a start pulse while busy.
        fault = 0;
        pulse_start1();
        repeat (9) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done1(11, 1'b0, cyc);
        chk("restart_cycle", cyc, 65);
        chk("restart_err",   int'(err1), 0);
        chk("restart_pass",  int'(pass1), 1);
        // start in the DONE cycle is dropped.
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        seen = 0;
        repeat (4) begin
            if (busy1 || done1) seen++;
            @(negedge clk);
        end
        chk("start_in_done", seen, 0);
        chk("pass_before_sa", int'(pass1), 1);
        start1 = 1'b1; abort1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; abort1 = 1'b0;
        chk("start_abort_busy", int'(busy1), 0);
        chk("start_abort_pass", int'(pass1), 0);
        @(negedge clk);
        chk("start_abort_busy2", int'(busy1), 0);

        // DWELL=0 instance: 2 cycles per vector.
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 1;
        while (!done2 && cyc < 100) begin
            if (cyc % 2 == 0)
                chk("walk0_abcd", int'({a2, b2, c2, d2}), cyc / 2 - 1);
            @(negedge clk);
            cyc++;
        end
        chk("d0_done_cycle", cyc, 33);
        chk("d0_pass", int'(pass2), 1);
        chk("d0_err",  int'(err2), 0);

        // Reset dropped mid-sweep at cycle 10.
        fault = 1;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (9) @(negedge clk);
        chk("d0_pre_rst_busy", int'(busy2), 1);
        #2 rst2_n = 1'b0;
        #1;
        chk("rst_async_busy", int'(busy2), 0);
        chk("rst_async_abcd", int'({a2, b2, c2, d2}), 0);
        chk("rst_async_err",  int'(err2), 0);
        chk("rst_async_fv",   int'(fv2), 0);
        chk("rst_async_pass", int'(pass2), 0);
        @(negedge clk);
        rst2_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done2 || busy2) seen++;
        end
        chk("rst_no_done", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
